// File: rtl/add_seq_wide_pkg.sv
// add_seq_wide_pkg
//   Shared definitions for the sequential wide adder:
//   - SLICE_W    : width of the reused carry-look-ahead slice
//   - state_t    : controller states (IDLE, RUN, DONE)
//   - cnt_width(): slice-counter width for a given slice count, never below 1
package add_seq_wide_pkg;

   localparam int SLICE_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int cnt_width(input int nslice);
      int w;
      w = $clog2(nslice);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/cla_16bits.sv
// cla_16bits
//   16-bit carry-look-ahead adder, purely combinational. Four 4-bit groups,
//   each producing group generate/propagate; group carries are expanded in
//   closed form so no carry ripples through the whole slice.
//   Ports:
//     x, y  : 16-bit addends
//     carry : carry into bit 0
//     sum   : x + y + carry, low 16 bits
//     cout  : carry out of bit 15
module cla_16bits (
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic        carry,
   output logic [15:0] sum,
   output logic        cout
);

   logic [15:0] g;
   logic [15:0] p;
   logic [15:0] c;
   logic [3:0]  gg;
   logic [3:0]  gp;
   logic [4:0]  gc;

   assign g = x & y;
   assign p = x ^ y;

   always_comb begin
      gg = '0;
      gp = '0;
      for (int j = 0; j < 4; j++) begin
         gp[j] = &p[4*j +: 4];
         gg[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      end
   end

   // Group carries written out fully so each depends only on carry and gg/gp.
   always_comb begin
      gc    = '0;
      gc[0] = carry;
      gc[1] = gg[0] | (gp[0] & carry);
      gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & carry);
      gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
            | (gp[2] & gp[1] & gp[0] & carry);
      gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
            | (gp[3] & gp[2] & gp[1] & gg[0])
            | (gp[3] & gp[2] & gp[1] & gp[0] & carry);
   end

   always_comb begin
      c = '0;
      for (int j = 0; j < 4; j++) begin
         c[4*j]   = gc[j];
         c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
         c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
         c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                  | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
      end
   end

   assign sum  = p ^ c;
   assign cout = gc[4];

endmodule

// File: rtl/add_seq_wide.sv
// add_seq_wide
//   Wide adder that reuses one 16-bit CLA slice, one slice per clock,
//   least-significant slice first. The inter-slice carry is registered.
//   Ports:
//     clk, rst_n           : clock, synchronous active-low reset
//     in_valid / in_ready  : operand handshake (a, b, c_in latched on accept)
//     out_valid / out_ready: result handshake (sum, c_out, ovf held while valid)
//     a, b                 : W-bit operands, W = 16*NSLICE
//     c_in                 : carry into slice 0
//     sum                  : a + b + c_in modulo 2^W
//     c_out                : carry out of bit W-1
//     ovf                  : two's-complement overflow
module add_seq_wide
   import add_seq_wide_pkg::*;
#(
   parameter int NSLICE = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [SLICE_W*NSLICE-1:0] a,
   input  logic [SLICE_W*NSLICE-1:0] b,
   input  logic                      c_in,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [SLICE_W*NSLICE-1:0] sum,
   output logic                      c_out,
   output logic                      ovf
);

   localparam int W  = SLICE_W * NSLICE;
   localparam int CW = cnt_width(NSLICE);

   state_t              state;
   state_t              state_nxt;
   logic [W-1:0]        a_reg;
   logic [W-1:0]        b_reg;
   logic [W-1:0]        sum_reg;
   logic                carry_reg;
   logic                ovf_reg;
   logic [CW-1:0]       k;
   logic                last;
   logic                accept;
   logic [SLICE_W-1:0]  cla_x;
   logic [SLICE_W-1:0]  cla_y;
   logic [SLICE_W-1:0]  cla_sum;
   logic                cla_cout;

   assign last   = (k == CW'(NSLICE - 1));
   assign accept = (state == IDLE) && in_valid;

   assign cla_x = a_reg[int'(k)*SLICE_W +: SLICE_W];
   assign cla_y = b_reg[int'(k)*SLICE_W +: SLICE_W];

   cla_16bits u_cla (
      .x     (cla_x),
      .y     (cla_y),
      .carry (carry_reg),
      .sum   (cla_sum),
      .cout  (cla_cout)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Operand registers only change on an accepted handshake; they need no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_reg <= a;
         b_reg <= b;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         ovf_reg   <= 1'b0;
         k         <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  carry_reg <= c_in;
                  k         <= '0;
               end
            end
            RUN: begin
               sum_reg[int'(k)*SLICE_W +: SLICE_W] <= cla_sum;
               carry_reg <= cla_cout;
               k         <= k + 1'b1;
               // sum^a^b at the MSB recovers the carry into bit W-1.
               if (last) begin
                  ovf_reg <= cla_sum[SLICE_W-1] ^ a_reg[W-1] ^ b_reg[W-1] ^ cla_cout;
               end
            end
            default: ;
         endcase
      end
   end

   assign sum   = sum_reg;
   assign c_out = carry_reg;
   assign ovf   = ovf_reg;

endmodule

// File: tb/tb_add_seq_wide.sv
// tb_add_seq_wide
//   Directed and randomized bench for add_seq_wide (NSLICE=4, W=64).
//   Expected results come from a (W+1)-bit arithmetic reference model.
module tb_add_seq_wide;

   localparam int NSLICE = 4;
   localparam int W      = 16 * NSLICE;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         c_out;
   logic         ovf;

   int n_pass = 0;
   int n_chk  = 0;

   int unsigned cyc = 0;
   int unsigned acc_cyc[$];

   always #5 clk = ~clk;

   add_seq_wide #(.NSLICE(NSLICE)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out),
      .ovf       (ovf)
   );

   // Records the cycle number of every accepted operand set.
   always @(posedge clk) begin
      if (rst_n && in_valid && in_ready) acc_cyc.push_back(cyc);
      cyc <= cyc + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic ref_model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                            output logic [W-1:0] s, output logic co, output logic ov);
      logic [W:0] t;
      t  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      s  = t[W-1:0];
      co = t[W];
      ov = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
   endtask

   task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      chk("in_ready_wait", {{W{1'b0}}, in_ready}, 1);
      a        = x;
      b        = y;
      c_in     = ci;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_result();
      int lat;
      lat = 1;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      chk("latency", (W+1)'(lat), (W+1)'(NSLICE + 1));
   endtask

   task automatic check_result(input string tag, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic ci);
      logic [W-1:0] s;
      logic         co;
      logic         ov;
      ref_model(x, y, ci, s, co, ov);
      chk({tag, "_sum"}, {1'b0, sum}, {1'b0, s});
      chk({tag, "_cout"}, {{W{1'b0}}, c_out}, {{W{1'b0}}, co});
      chk({tag, "_ovf"}, {{W{1'b0}}, ovf}, {{W{1'b0}}, ov});
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("post_hs_out_valid", {{W{1'b0}}, out_valid}, 0);
      chk("post_hs_in_ready", {{W{1'b0}}, in_ready}, 1);
   endtask

   task automatic run_directed(input string tag, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic ci);
      start_op(x, y, ci);
      wait_result();
      check_result(tag, x, y, ci);
      release_out();
   endtask

   initial begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         ci;
      logic [W-1:0] s_ref;
      logic         co_ref;
      logic         ov_ref;
      int           stall;
      int unsigned  sel;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      c_in      = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      chk("rst_in_ready", {{W{1'b0}}, in_ready}, 1);
      chk("rst_out_valid", {{W{1'b0}}, out_valid}, 0);
      chk("rst_sum", {1'b0, sum}, 0);
      chk("rst_cout", {{W{1'b0}}, c_out}, 0);
      chk("rst_ovf", {{W{1'b0}}, ovf}, 0);

      // Directed corner cases
      run_directed("simple", 64'd1, 64'd2, 1'b0);
      run_directed("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
      run_directed("ovf_pos", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      run_directed("ovf_neg", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
      run_directed("slice_carry", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0);

      // Backpressure: outputs frozen, no accept, exactly one result
      x  = 64'h1234_5678_9ABC_DEF0;
      y  = 64'hFEDC_BA98_7654_3210;
      ci = 1'b1;
      ref_model(x, y, ci, s_ref, co_ref, ov_ref);
      acc_cyc.delete();
      start_op(x, y, ci);
      wait_result();
      for (int i = 0; i < 10; i++) begin
         a        = {$urandom, $urandom};
         b        = {$urandom, $urandom};
         c_in     = 1'($urandom);
         in_valid = 1'($urandom);
         tick();
         chk("bp_in_ready", {{W{1'b0}}, in_ready}, 0);
         chk("bp_out_valid", {{W{1'b0}}, out_valid}, 1);
         chk("bp_sum", {1'b0, sum}, {1'b0, s_ref});
         chk("bp_cout", {{W{1'b0}}, c_out}, {{W{1'b0}}, co_ref});
         chk("bp_ovf", {{W{1'b0}}, ovf}, {{W{1'b0}}, ov_ref});
      end
      in_valid = 1'b0;
      release_out();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_no_extra", {{W{1'b0}}, out_valid}, 0);
      end
      chk("bp_one_accept", (W+1)'(acc_cyc.size()), 1);

      // Reset in the middle of RUN (slice k=2)
      start_op(64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b0);
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("midrst_in_ready", {{W{1'b0}}, in_ready}, 1);
      chk("midrst_out_valid", {{W{1'b0}}, out_valid}, 0);
      chk("midrst_sum", {1'b0, sum}, 0);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("midrst_no_result", {{W{1'b0}}, out_valid}, 0);
      end
      run_directed("after_rst", 64'h0123_4567_89AB_CDEF, 64'h0F0F_0F0F_F0F0_F0F0, 1'b1);

      // Randomized operations with random result stalls
      for (int i = 0; i < 1000; i++) begin
         sel = $urandom_range(0, 7);
         x   = {$urandom, $urandom};
         y   = {$urandom, $urandom};
         if (sel == 0) x = '1;
         if (sel == 1) y = '0;
         if (sel == 2) y = ~x;
         ci = 1'($urandom);
         ref_model(x, y, ci, s_ref, co_ref, ov_ref);
         start_op(x, y, ci);
         wait_result();
         check_result("rand", x, y, ci);
         stall = $urandom_range(0, 3);
         for (int j = 0; j < stall; j++) begin
            a = {$urandom, $urandom};
            tick();
            chk("rand_stall_sum", {1'b0, sum}, {1'b0, s_ref});
         end
         release_out();
      end

      // Throughput with out_ready and in_valid held high
      acc_cyc.delete();
      a         = 64'd5;
      b         = 64'd7;
      c_in      = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3 * (NSLICE + 2) + 2; i++) tick();
      in_valid = 1'b0;
      for (int i = 0; i < 2 * (NSLICE + 2); i++) tick();
      out_ready = 1'b0;
      chk("tput_count", (W+1)'(acc_cyc.size() >= 3), 1);
      if (acc_cyc.size() >= 3) begin
         chk("tput_gap0", (W+1)'(acc_cyc[1] - acc_cyc[0]), (W+1)'(NSLICE + 2));
         chk("tput_gap1", (W+1)'(acc_cyc[2] - acc_cyc[1]), (W+1)'(NSLICE + 2));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/add_seq_wide.md
# add_seq_wide

Multi-cycle wide adder controller that reuses one 16-bit carry-look-ahead slice to add N×16-bit operands, one 16-bit slice per clock, least-significant slice first. It sits directly upstream of the 16-bit CLA: it latches wide operands, feeds slice operands and a registered carry into the CLA, and collects the slice sums and final carry. Wide operands arrive and results leave through valid/ready handshakes.

## Interface
- NSLICE, 4, number of 16-bit slices; operand width W = 16*NSLICE; legal range 2..8
- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  reset; synchronous and active-low
- in_valid  in  1  operand set valid
- in_ready  out  1  block can accept operands
- a  in  W  operand A
- b  in  W  operand B
- c_in  in  1  carry into slice 0
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  W  A + B + c_in, modulo 2^W
- c_out  out  1  carry out of bit W-1
- ovf  out  1  signed overflow: carry into bit W-1 XOR c_out

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b into operand regs; latch c_in into carry reg; clear slice counter; go to RUN.
- RUN, one slice per cycle with counter k = 0..NSLICE-1:
  - CLA inputs: x=a_reg[16k+:16], y=b_reg[16k+:16], carry=carry reg.
  - At the clock edge: write the CLA sum into sum_reg[16k+:16] and the CLA carry-out into the carry reg; k increments.
  - At k=NSLICE-1: also capture ovf = sum[W-1]^a_reg[W-1]^b_reg[W-1]^cla_carry_out, then go to DONE.
- DONE:
  - out_valid=1; sum, c_out (=carry reg) and ovf stay stable.
  - On out_ready, go to IDLE.
  - in_ready=0 in DONE; no same-cycle re-accept.
- Inputs a, b and c_in are ignored outside an IDLE handshake. Changing them mid-operation has no effect.
- in_valid and out_ready are don't-care in states where they are not sampled.
- Arithmetic is unsigned modulo 2^W. ovf interprets the operands as two's complement.
- sum_reg slices not yet written in RUN hold their previous values. The outputs are defined only while out_valid=1.

## Timing
- Reset (rst_n=0 at an edge):
  - state=IDLE, counter=0, sum=0, c_out=0, ovf=0, out_valid=0, in_ready=1 from the next cycle.
  - Reset mid-RUN or mid-DONE aborts the operation. No result is ever presented for the aborted operation.
- Latency:
  - The accept edge is at cycle T.
  - RUN occupies cycles T+1..T+NSLICE.
  - out_valid is high from cycle T+NSLICE+1 (T+5 for NSLICE=4).
- Throughput: with out_ready held high, one operation per NSLICE+2 cycles (accept, NSLICE slices, one DONE cycle).
- Backpressure: DONE holds indefinitely while out_ready=0, with outputs frozen.
- out_valid falls in the cycle after the out_ready handshake. in_ready rises in the same cycle.
- Carry chain: the CLA carry path is combinational within one cycle. The inter-slice carry is always registered.

## Structure
- Shared package holds:
  - SLICE_W=16.
  - The state enum (IDLE, RUN, DONE).
  - A function computing the counter width, clog2(NSLICE), minimum 1.
- One sub-module: a single instance of the existing 16-bit carry-look-ahead adder (cla_16bits) as the slice datapath.
- No other sub-modules. Operand regs, sum reg, carry reg, counter and FSM live in the top.

## Test plan
- Reset then simple add, NSLICE=4: a=1, b=2, c_in=0 -> out_valid at T+5; sum=3, c_out=0, ovf=0.
- Full carry ripple across all slices: a=0xFFFF_FFFF_FFFF_FFFF, b=0, c_in=1 -> sum=0, c_out=1, ovf=0.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, c_in=0 -> sum=0x8000_0000_0000_0000, c_out=0, ovf=1. Also a=b=0x8000_0000_0000_0000 -> sum=0, c_out=1, ovf=1.
- Backpressure and input stability:
  - Hold out_ready=0 for 10 cycles after out_valid and toggle a/b/in_valid meanwhile.
  - Required: in_ready=0 throughout; outputs frozen; exactly one result per accepted operand set.
- Reset mid-RUN: assert rst_n=0 at slice k=2 -> the next cycle shows IDLE, in_ready=1, out_valid=0, sum=0. The next operation computes correctly.
- Back-to-back random: 1000 random a/b/c_in with random out_ready stalls, compared against a W+1-bit reference sum and ovf model. Also check the NSLICE+2 cycle spacing when out_ready=1.
